// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: merges jump, JEQ, load-use and memory-wait
// hazards into per-stage write/flush controls, with a wait timeout and a lost-cycle counter.
module pipeline_hazard_sequencer #(
  parameter int unsigned REGW = 5,
  parameter int unsigned TMO  = 16,
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            JMPControl,
  input  logic            JEQControl,
  input  logic            ID_EXMemRead,
  input  logic [REGW-1:0] ID_EXRd,
  input  logic [REGW-1:0] IF_IDRs,
  input  logic [REGW-1:0] IF_IDRt,
  input  logic            MEM_REQ,
  input  logic            MEM_READY,
  output logic            PCWrite,
  output logic            IF_IDWrite,
  output logic            ID_EXWrite,
  output logic            EX_MAWrite,
  output logic            IF_IDFLUSH,
  output logic            ID_EXFLUSH,
  output logic            EX_MAFLUSH,
  output logic            MA_WBFLUSH,
  output logic            MEM_ERR,
  output logic [CNTW-1:0] STALL_CNT
);

  localparam int unsigned TmrW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TMO - 1);

  typedef enum logic [1:0] {StRun, StLdStall, StMemWait, StRedir} state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] timer_q;
  logic            mem_err_q;
  logic [CNTW-1:0] stall_cnt_q;

  logic mw, lu, redirect, lost_cycle;

  assign mw       = MEM_REQ & ~MEM_READY;
  assign lu       = ID_EXMemRead && (ID_EXRd != '0) &&
                    ((ID_EXRd == IF_IDRs) || (ID_EXRd == IF_IDRt));
  assign redirect = JEQControl | JMPControl;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StRun;
    unique case (state_q)
      StRun: begin
        if (mw) begin
          state_d = StMemWait;
        end else if (redirect) begin
          state_d = StRedir;
        end else if (lu) begin
          state_d = StLdStall;
        end
      end
      StLdStall, StMemWait, StRedir: begin
        if (mw) state_d = StMemWait;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b1;
    IF_IDWrite = 1'b1;
    ID_EXWrite = 1'b1;
    EX_MAWrite = 1'b1;
    IF_IDFLUSH = 1'b0;
    ID_EXFLUSH = 1'b0;
    EX_MAFLUSH = 1'b0;
    MA_WBFLUSH = 1'b0;
    if (RST) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXWrite = 1'b0;
      EX_MAWrite = 1'b0;
      IF_IDFLUSH = 1'b1;
      ID_EXFLUSH = 1'b1;
      EX_MAFLUSH = 1'b1;
      MA_WBFLUSH = 1'b1;
    end else if (mw) begin
      // Freeze everything upstream of MA; pending redirects act once the wait releases.
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXWrite = 1'b0;
      EX_MAWrite = 1'b0;
      MA_WBFLUSH = 1'b1;
    end else if (JEQControl) begin
      IF_IDFLUSH = 1'b1;
      ID_EXFLUSH = 1'b1;
      EX_MAFLUSH = 1'b1;
    end else if (JMPControl) begin
      IF_IDFLUSH = 1'b1;
      ID_EXFLUSH = 1'b1;
    end else if (lu && (state_q != StRedir)) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFLUSH = 1'b1;
    end
  end

  assign lost_cycle = ~(PCWrite & IF_IDWrite & ID_EXWrite & EX_MAWrite) |
                      IF_IDFLUSH | ID_EXFLUSH | EX_MAFLUSH | MA_WBFLUSH;

  // Timer counts every wait cycle, including the one that leaves RUN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer_q   <= '0;
      mem_err_q <= 1'b0;
    end else if (mw) begin
      if (timer_q == TmrLast) begin
        mem_err_q <= 1'b1;
      end else begin
        timer_q <= timer_q + TmrW'(1);
      end
    end else begin
      timer_q <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else if (lost_cycle && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNTW'(1);
    end
  end

  assign MEM_ERR   = mem_err_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench for pipeline_hazard_sequencer (TMO=4, CNTW=4): a behavioural model pushes
// expected controls per driven cycle; the negedge checker pops and compares.
module tb_pipeline_hazard_sequencer;

  localparam int unsigned Tmo  = 4;
  localparam int unsigned Cntw = 4;

  logic       clk;
  logic       rst, jmp, jeq, mrd, req, rdy;
  logic [4:0] rd, rs, rt;
  logic       pc_we, ifid_we, idex_we, exma_we;
  logic       ifid_fl, idex_fl, exma_fl, mawb_fl;
  logic       mem_err;
  logic [Cntw-1:0] stall_cnt;

  pipeline_hazard_sequencer #(
    .REGW(5),
    .TMO (Tmo),
    .CNTW(Cntw)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .JMPControl  (jmp),
    .JEQControl  (jeq),
    .ID_EXMemRead(mrd),
    .ID_EXRd     (rd),
    .IF_IDRs     (rs),
    .IF_IDRt     (rt),
    .MEM_REQ     (req),
    .MEM_READY   (rdy),
    .PCWrite     (pc_we),
    .IF_IDWrite  (ifid_we),
    .ID_EXWrite  (idex_we),
    .EX_MAWrite  (exma_we),
    .IF_IDFLUSH  (ifid_fl),
    .ID_EXFLUSH  (idex_fl),
    .EX_MAFLUSH  (exma_fl),
    .MA_WBFLUSH  (mawb_fl),
    .MEM_ERR     (mem_err),
    .STALL_CNT   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] w;    // {PC, IF/ID, ID/EX, EX/MA}
    logic [3:0] f;    // {IF/ID, ID/EX, EX/MA, MA/WB}
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Model state: 0 run, 1 load stall, 2 mem wait, 3 redirect shadow
  int   m_st   = 0;
  int   m_tmr  = 0;
  logic m_err  = 1'b0;
  int   m_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_e = sb.pop_front();
      check_eq("write", {28'd0, pc_we, ifid_we, idex_we, exma_we}, {28'd0, sb_e.w});
      check_eq("flush", {28'd0, ifid_fl, idex_fl, exma_fl, mawb_fl}, {28'd0, sb_e.f});
      check_eq("mem_err", {31'd0, mem_err}, {31'd0, sb_e.err});
      check_eq("stall_cnt", {28'd0, stall_cnt}, {28'd0, sb_e.cnt});
    end
  end

  task automatic step(input logic r, input logic j, input logic q, input logic m,
                      input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                      input logic mq, input logic my);
    exp_t e;
    logic wait_c, load_use;
    @(posedge clk);
    #1;
    rst = r; jmp = j; jeq = q; mrd = m; rd = d; rs = s; rt = t; req = mq; rdy = my;
    wait_c   = mq && !my;
    load_use = m && (d != 0) && (d == s || d == t);
    e.err = m_err;
    e.cnt = 4'(m_cnt);
    e.w   = 4'b1111;
    e.f   = 4'b0000;
    if (r) begin
      e.w = 4'b0000; e.f = 4'b1111;
    end else if (wait_c) begin
      e.w = 4'b0000; e.f = 4'b0001;
    end else if (q) begin
      e.f = 4'b1110;
    end else if (j) begin
      e.f = 4'b1100;
    end else if (load_use && m_st != 3) begin
      e.w = 4'b0011; e.f = 4'b0100;
    end
    sb.push_back(e);
    if (r) begin
      m_st = 0; m_tmr = 0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if ((e.w != 4'b1111 || e.f != 4'b0000) && m_cnt < 15) m_cnt++;
      if (wait_c) begin
        if (m_tmr == Tmo - 1) m_err = 1'b1;
        else m_tmr++;
      end else begin
        m_tmr = 0;
      end
      if (wait_c) m_st = 2;
      else if (m_st == 0 && (j || q)) m_st = 3;
      else if (m_st == 0 && load_use) m_st = 1;
      else m_st = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; jmp = 0; jeq = 0; mrd = 0; req = 0; rdy = 0; rd = 0; rs = 0; rt = 0;
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    // Load-use on Rs, then on Rt, then on r0 (no stall)
    step(0, 0, 0, 1, 5'd3, 5'd3, 5'd7, 0, 0);
    idle();
    step(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 0);
    step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 0, 5'd3, 5'd3, 5'd3, 0, 0);
    // MEM_READY without MEM_REQ is ignored
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    // JMP+JEQ together, then load-use in the redirect shadow is suppressed
    step(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0);
    step(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0);
    idle();
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // Five frozen cycles with a pending jump, release applies the jump flush
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1);
    idle();
    idle();
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // Timeout: six wait cycles, error sticky afterwards until reset
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1);
    idle();
    idle();
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    // Saturation: continuous load-use stalls, reset mid-way, then saturate
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0);
    step(1, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 5'd4, 5'd0, 5'd4, 0, 0);
    idle();
    idle();
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
